// File: rtl/mt_xlat_if.sv
// MBOX-to-SBUS translator bundle: MBOX request/data handshakes plus the SBUS memory-port signals.
// master = request/response side (MBOX and memories), slave = mt_xlat.
interface mt_xlat_if #(
    parameter int NPORTS = 2,
    parameter int DW     = 36,
    parameter int AW     = 22,
    parameter int NWORDS = 4
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic              RQ_VALID;
    logic              RQ_READY;
    logic [AW-1:0]     RQ_ADR;
    logic              RQ_WR;
    logic [NWORDS-1:0] RQ_MASK;
    logic [DW-1:0]     WD_DATA;
    logic              WD_VALID;
    logic              WD_READY;
    logic [DW-1:0]     RD_DATA;
    logic [IW-1:0]     RD_IDX;
    logic              RD_VALID;
    logic              RD_PAR_ERR;
    logic              DONE;
    logic              ERR;
    logic [1:0]        ERR_CODE;

    logic [NPORTS-1:0] SB_START;
    logic [NWORDS-1:0] SB_RQ;
    logic              SB_RD_RQ;
    logic              SB_WR_RQ;
    logic [AW-1:0]     SB_ADR;
    logic              SB_ADR_PAR;
    logic [NPORTS-1:0] SB_ACKN;
    logic [NPORTS-1:0] SB_ERROR;
    logic [NPORTS-1:0] SB_ADR_PAR_ERR;
    logic [NPORTS-1:0] SB_DVALID_IN;
    logic [DW-1:0]     SB_D_IN;
    logic [DW-1:0]     SB_D_OUT;
    logic              SB_DPAR_IN;
    logic              SB_DPAR_OUT;
    logic              SB_DVALID_OUT;
    logic              SB_D_OE;

    modport master (
        output RQ_VALID, RQ_ADR, RQ_WR, RQ_MASK, WD_DATA, WD_VALID,
        output SB_ACKN, SB_ERROR, SB_ADR_PAR_ERR, SB_DVALID_IN, SB_D_IN, SB_DPAR_IN,
        input  RQ_READY, WD_READY, RD_DATA, RD_IDX, RD_VALID, RD_PAR_ERR, DONE, ERR, ERR_CODE,
        input  SB_START, SB_RQ, SB_RD_RQ, SB_WR_RQ, SB_ADR, SB_ADR_PAR,
        input  SB_D_OUT, SB_DPAR_OUT, SB_DVALID_OUT, SB_D_OE
    );

    modport slave (
        input  RQ_VALID, RQ_ADR, RQ_WR, RQ_MASK, WD_DATA, WD_VALID,
        input  SB_ACKN, SB_ERROR, SB_ADR_PAR_ERR, SB_DVALID_IN, SB_D_IN, SB_DPAR_IN,
        output RQ_READY, WD_READY, RD_DATA, RD_IDX, RD_VALID, RD_PAR_ERR, DONE, ERR, ERR_CODE,
        output SB_START, SB_RQ, SB_RD_RQ, SB_WR_RQ, SB_ADR, SB_ADR_PAR,
        output SB_D_OUT, SB_DPAR_OUT, SB_DVALID_OUT, SB_D_OE
    );
endinterface

// File: rtl/mt_xlat.sv
// Translates one MBOX quad request into an SBUS start/ack/data sequence on the port chosen by
// the address bits just above the word index; reports completion, timeout and SBUS errors.
module mt_xlat #(
    parameter int NPORTS  = 2,
    parameter int DW      = 36,
    parameter int AW      = 22,
    parameter int NWORDS  = 4,
    parameter int ACK_TMO = 255
) (
    input  logic        CLK,
    input  logic        CROBAR,
    mt_xlat_if.slave    bus
);
    localparam int IS = $clog2(NWORDS);
    localparam int IW = (IS > 0) ? IS : 1;
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int TW = $clog2(ACK_TMO + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_ACK, S_XFER, S_DONE, S_ERR} state_t;

    state_t            r_state, w_nxt;
    logic [AW-1:0]     r_adr;
    logic              r_wr;
    logic [NWORDS-1:0] r_mask;
    logic [PW-1:0]     r_port;
    logic [TW-1:0]     r_tmr;
    logic [1:0]        r_code, w_code;
    logic [DW-1:0]     r_rd_data;
    logic [IW-1:0]     r_rd_idx;
    logic              r_rd_valid, r_rd_par_err;
    logic [DW-1:0]     r_d_out;
    logic              r_dpar_out, r_dv_out;

    logic [PW-1:0]     w_port_in;
    logic [NPORTS-1:0] w_sel;
    logic              w_ackn, w_sberr, w_aperr, w_dvalid;
    logic              w_tmo, w_wd_ready, w_wd_acc, w_active, w_hold;
    logic [NWORDS-1:0] w_mask_rest;
    logic [IW-1:0]     w_low_idx;

    generate
        if (NPORTS > 1) begin : g_port
            assign w_port_in = bus.RQ_ADR[IS +: PW];
        end else begin : g_port1
            assign w_port_in = '0;
        end
    endgenerate

    // Only the selected port's responses are seen by the sequencer.
    assign w_sel       = NPORTS'(1) << r_port;
    assign w_ackn      = |(bus.SB_ACKN & w_sel);
    assign w_sberr     = |(bus.SB_ERROR & w_sel);
    assign w_aperr     = |(bus.SB_ADR_PAR_ERR & w_sel);
    assign w_dvalid    = |(bus.SB_DVALID_IN & w_sel);
    assign w_mask_rest = r_mask & (r_mask - NWORDS'(1));
    assign w_tmo       = (r_tmr == TW'(ACK_TMO - 1));
    assign w_wd_ready  = (r_state == S_XFER) && r_wr && !r_dv_out && (r_mask != '0);
    assign w_wd_acc    = w_wd_ready && bus.WD_VALID;
    assign w_active    = (r_state == S_START) || (r_state == S_ACK) || (r_state == S_XFER);
    assign w_hold      = (r_state == S_START) || (r_state == S_ACK);

    always_comb begin
        w_low_idx = '0;
        for (int i = NWORDS - 1; i >= 0; i--)
            if (r_mask[i]) w_low_idx = IW'(i);
    end

    always_ff @(posedge CLK) begin
        if (CROBAR) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt  = r_state;
        w_code = 2'd0;
        case (r_state)
            S_IDLE:  if (bus.RQ_VALID) w_nxt = (bus.RQ_MASK == '0) ? S_DONE : S_START;
            S_START: w_nxt = S_ACK;
            S_ACK: begin
                if (w_sberr)                 begin w_nxt = S_ERR; w_code = 2'd3; end
                else if (w_ackn && w_aperr)  begin w_nxt = S_ERR; w_code = 2'd2; end
                else if (w_ackn)             w_nxt = S_XFER;
                else if (w_tmo)              begin w_nxt = S_ERR; w_code = 2'd1; end
            end
            S_XFER: begin
                if (w_sberr) begin
                    w_nxt = S_ERR; w_code = 2'd3;
                end else if (!r_wr) begin
                    if (w_dvalid) begin
                        if (w_mask_rest == '0) w_nxt = S_DONE;
                    end else if (w_tmo) begin
                        w_nxt = S_ERR; w_code = 2'd1;
                    end
                // a write finishes only after its last word has been strobed onto the bus
                end else if (r_dv_out && (r_mask == '0)) begin
                    w_nxt = S_DONE;
                end else if (!w_wd_acc && w_tmo) begin
                    w_nxt = S_ERR; w_code = 2'd1;
                end
            end
            S_DONE:  w_nxt = S_IDLE;
            S_ERR:   w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.RQ_READY      = (r_state == S_IDLE) && !CROBAR;
        bus.WD_READY      = w_wd_ready;
        bus.RD_DATA       = r_rd_data;
        bus.RD_IDX        = r_rd_idx;
        bus.RD_VALID      = r_rd_valid;
        bus.RD_PAR_ERR    = r_rd_par_err;
        bus.DONE          = (r_state == S_DONE);
        bus.ERR           = (r_state == S_ERR);
        bus.ERR_CODE      = (r_state == S_ERR) ? r_code : 2'd0;
        bus.SB_START      = w_hold ? w_sel : '0;
        bus.SB_RQ         = w_hold ? r_mask : '0;
        bus.SB_RD_RQ      = w_active && !r_wr;
        bus.SB_WR_RQ      = w_active && r_wr;
        bus.SB_ADR        = w_active ? r_adr : '0;
        bus.SB_ADR_PAR    = w_active && ~^r_adr;
        bus.SB_D_OUT      = r_dv_out ? r_d_out : '0;
        bus.SB_DPAR_OUT   = r_dv_out && r_dpar_out;
        bus.SB_DVALID_OUT = r_dv_out;
        bus.SB_D_OE       = (r_state == S_XFER) && r_wr;
    end

    always_ff @(posedge CLK) begin
        if (CROBAR) begin
            r_adr        <= '0;
            r_wr         <= 1'b0;
            r_mask       <= '0;
            r_port       <= '0;
            r_tmr        <= '0;
            r_code       <= 2'd0;
            r_rd_data    <= '0;
            r_rd_idx     <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_par_err <= 1'b0;
            r_d_out      <= '0;
            r_dpar_out   <= 1'b0;
            r_dv_out     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_dv_out   <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.RQ_VALID) begin
                    r_adr  <= bus.RQ_ADR;
                    r_wr   <= bus.RQ_WR;
                    r_mask <= bus.RQ_MASK;
                    r_port <= w_port_in;
                end
                S_START: r_tmr <= '0;
                S_ACK:   r_tmr <= w_ackn ? '0 : r_tmr + TW'(1);
                S_XFER: begin
                    if (!r_wr && w_dvalid && !w_sberr) begin
                        r_rd_data    <= bus.SB_D_IN;
                        r_rd_idx     <= w_low_idx;
                        r_rd_valid   <= 1'b1;
                        r_rd_par_err <= ~(^bus.SB_D_IN ^ bus.SB_DPAR_IN);
                        r_mask       <= w_mask_rest;
                        r_tmr        <= '0;
                    end else if (w_wd_acc && !w_sberr) begin
                        r_d_out    <= bus.WD_DATA;
                        r_dpar_out <= ~^bus.WD_DATA;
                        r_dv_out   <= 1'b1;
                        r_mask     <= w_mask_rest;
                        r_tmr      <= '0;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                default: ;
            endcase
            if (w_nxt == S_ERR) r_code <= w_code;
        end
    end
endmodule

// File: tb/tb_mt_xlat.sv
// Directed bench for mt_xlat: read, write, empty mask, timeout, address/SBUS errors, mid-transfer reset.
module tb_mt_xlat;
    logic clk = 1'b0;
    logic crobar;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_err = 0;
    int   n_dvo = 0;
    int   d0, e0;

    logic [35:0] rw  [4] = '{36'h000000001, 36'h000000003, 36'h0000000FF, 36'h800000007};
    logic        rp  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        rpe [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    mt_xlat_if #(.NPORTS(2), .DW(36), .AW(22), .NWORDS(4)) bus ();

    mt_xlat #(.NPORTS(2), .DW(36), .AW(22), .NWORDS(4), .ACK_TMO(255)) u_dut (
        .CLK    (clk),
        .CROBAR (crobar),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.DONE)          n_done <= n_done + 1;
        if (bus.ERR)           n_err  <= n_err + 1;
        if (bus.SB_DVALID_OUT) n_dvo  <= n_dvo + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one request for a cycle; returns one cycle later with the request withdrawn.
    task automatic issue(input logic [21:0] adr, input logic wr, input logic [3:0] mask);
        bus.RQ_VALID = 1'b1;
        bus.RQ_ADR   = adr;
        bus.RQ_WR    = wr;
        bus.RQ_MASK  = mask;
        step();
        bus.RQ_VALID = 1'b0;
    endtask

    initial begin
        crobar = 1'b1;
        bus.RQ_VALID = 0; bus.RQ_ADR = '0; bus.RQ_WR = 0; bus.RQ_MASK = '0;
        bus.WD_DATA = '0; bus.WD_VALID = 0;
        bus.SB_ACKN = '0; bus.SB_ERROR = '0; bus.SB_ADR_PAR_ERR = '0; bus.SB_DVALID_IN = '0;
        bus.SB_D_IN = '0; bus.SB_DPAR_IN = 0;
        repeat (3) step();
        chk("rst_rdy",   bus.RQ_READY, 0);
        chk("rst_start", bus.SB_START, 0);
        chk("rst_done",  {bus.DONE, bus.ERR, bus.ERR_CODE, bus.RD_VALID, bus.SB_D_OE}, 0);
        crobar = 1'b0;
        #1;
        chk("rel_rdy", bus.RQ_READY, 1);

        // quad read on port 1
        issue(22'o000004, 1'b0, 4'hF);
        chk("rd_start", bus.SB_START, 2'b10);
        chk("rd_rq",    bus.SB_RQ, 4'hF);
        chk("rd_dir",   {bus.SB_RD_RQ, bus.SB_WR_RQ}, 2'b10);
        chk("rd_adr",   bus.SB_ADR, 4);
        chk("rd_apar",  bus.SB_ADR_PAR, 0);
        step();
        bus.SB_ACKN = 2'b01; step();
        chk("rd_hold_start", bus.SB_START, 2'b10);
        chk("rd_hold_rq",    bus.SB_RQ, 4'hF);
        bus.SB_ACKN = 2'b00; step();
        bus.SB_ACKN = 2'b10; step();
        bus.SB_ACKN = 2'b00;
        chk("rd_xfer_start", bus.SB_START, 0);
        chk("rd_oe",         bus.SB_D_OE, 0);
        bus.SB_DVALID_IN = 2'b01; bus.SB_D_IN = 36'hABC; step();
        chk("rd_other_port", bus.RD_VALID, 0);
        for (int i = 0; i < 4; i++) begin
            bus.SB_DVALID_IN = 2'b10; bus.SB_D_IN = rw[i]; bus.SB_DPAR_IN = rp[i];
            step();
            chk("rd_valid", bus.RD_VALID, 1);
            chk("rd_idx",   bus.RD_IDX, i);
            chk("rd_data",  bus.RD_DATA, rw[i]);
            chk("rd_perr",  bus.RD_PAR_ERR, rpe[i]);
        end
        chk("rd_done",    bus.DONE, 1);
        chk("rd_done_rq", bus.SB_RD_RQ, 0);
        chk("rd_done_rdy", bus.RQ_READY, 0);
        bus.SB_DVALID_IN = 2'b00;
        step();
        chk("rd_idle_done", bus.DONE, 0);
        chk("rd_idle_rdy",  bus.RQ_READY, 1);
        chk("rd_done_cnt",  n_done, 1);

        // write, mask 0101, port 0
        bus.WD_VALID = 1'b1; bus.WD_DATA = 36'h3;
        issue(22'o000000, 1'b1, 4'b0101);
        chk("wr_start", bus.SB_START, 2'b01);
        chk("wr_dir",   {bus.SB_RD_RQ, bus.SB_WR_RQ}, 2'b01);
        chk("wr_rdy0",  bus.WD_READY, 0);
        chk("wr_oe0",   bus.SB_D_OE, 0);
        step();
        chk("wr_oe_ack", bus.SB_D_OE, 0);
        bus.SB_ACKN = 2'b01; step();
        bus.SB_ACKN = 2'b00;
        chk("wr_oe",   bus.SB_D_OE, 1);
        chk("wr_rdy1", bus.WD_READY, 1);
        chk("wr_dv0",  bus.SB_DVALID_OUT, 0);
        step();
        chk("wr_dv1",   bus.SB_DVALID_OUT, 1);
        chk("wr_d1",    bus.SB_D_OUT, 36'h3);
        chk("wr_par1",  bus.SB_DPAR_OUT, 1);
        chk("wr_rdy_busy", bus.WD_READY, 0);
        bus.WD_DATA = 36'h7;
        step();
        chk("wr_dv_gap", bus.SB_DVALID_OUT, 0);
        chk("wr_rdy2",   bus.WD_READY, 1);
        step();
        chk("wr_dv2",  bus.SB_DVALID_OUT, 1);
        chk("wr_d2",   bus.SB_D_OUT, 36'h7);
        chk("wr_par2", bus.SB_DPAR_OUT, 0);
        step();
        chk("wr_done",    bus.DONE, 1);
        chk("wr_done_oe", bus.SB_D_OE, 0);
        bus.WD_VALID = 1'b0;
        step();
        chk("wr_dv_cnt", n_dvo, 2);

        // empty mask completes without touching SBUS
        issue(22'o000004, 1'b0, 4'b0000);
        chk("m0_done",  bus.DONE, 1);
        chk("m0_start", {bus.SB_START, bus.SB_RD_RQ}, 0);
        step();

        // no acknowledge -> timeout
        issue(22'o000000, 1'b0, 4'b0001);
        step();
        repeat (254) step();
        chk("tmo_wait_err",   bus.ERR, 0);
        chk("tmo_wait_start", bus.SB_START, 2'b01);
        step();
        chk("tmo_err",   bus.ERR, 1);
        chk("tmo_code",  bus.ERR_CODE, 1);
        chk("tmo_start", bus.SB_START, 0);
        step();
        chk("tmo_idle", {bus.ERR, bus.RQ_READY}, 2'b01);

        // acknowledge with address parity error (port 0 SB_ERROR is noise)
        issue(22'o000004, 1'b0, 4'hF);
        step();
        bus.SB_ACKN = 2'b10; bus.SB_ADR_PAR_ERR = 2'b10; bus.SB_ERROR = 2'b01;
        step();
        chk("ape_err",  bus.ERR, 1);
        chk("ape_code", bus.ERR_CODE, 2);
        bus.SB_ACKN = 2'b00; bus.SB_ADR_PAR_ERR = 2'b00; bus.SB_ERROR = 2'b00;
        step();

        // SBUS ERROR together with bad data parity
        issue(22'o000000, 1'b0, 4'b0011);
        step();
        bus.SB_ACKN = 2'b01; step();
        bus.SB_ACKN = 2'b00;
        bus.SB_DVALID_IN = 2'b01; bus.SB_D_IN = 36'h1; bus.SB_DPAR_IN = 1'b1; bus.SB_ERROR = 2'b01;
        step();
        chk("sbe_err",  bus.ERR, 1);
        chk("sbe_code", bus.ERR_CODE, 3);
        bus.SB_DVALID_IN = 2'b00; bus.SB_ERROR = 2'b00;
        step();

        // reset in the middle of a read
        issue(22'o000010, 1'b0, 4'hF);
        step();
        bus.SB_ACKN = 2'b01; step();
        bus.SB_ACKN = 2'b00;
        bus.SB_DVALID_IN = 2'b01; bus.SB_D_IN = 36'h1; bus.SB_DPAR_IN = 1'b0;
        step();
        chk("mid_rdv", bus.RD_VALID, 1);
        d0 = n_done; e0 = n_err;
        crobar = 1'b1;
        step();
        chk("mid_rst_rdy", bus.RQ_READY, 0);
        chk("mid_rst_rd",  {bus.RD_VALID, bus.RD_DATA}, 0);
        chk("mid_rst_sb",  {bus.SB_RD_RQ, bus.SB_ADR, bus.SB_ADR_PAR, bus.SB_START}, 0);
        chk("mid_rst_st",  {bus.DONE, bus.ERR, bus.ERR_CODE}, 0);
        crobar = 1'b0; bus.SB_DVALID_IN = 2'b00;
        #1;
        chk("mid_rel_rdy", bus.RQ_READY, 1);
        repeat (3) step();
        chk("mid_no_done", n_done, d0);
        chk("mid_no_err",  n_err, e0);
        issue(22'o000004, 1'b0, 4'b0010);
        step();
        bus.SB_ACKN = 2'b10; step();
        bus.SB_ACKN = 2'b00;
        bus.SB_DVALID_IN = 2'b10; bus.SB_D_IN = 36'h3; bus.SB_DPAR_IN = 1'b1;
        step();
        chk("post_done", bus.DONE, 1);
        chk("post_idx",  bus.RD_IDX, 1);
        chk("post_data", bus.RD_DATA, 36'h3);
        bus.SB_DVALID_IN = 2'b00;
        step();
        chk("post_cnt", n_done, d0 + 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mt_xlat.md
MT_XLAT -- requirements
Module: mt_xlat

Interface
REQ-001 SHALL take parameter NPORTS, default 2: number of SBUS memory ports (1..4).
REQ-002 SHALL take parameter DW, default 36: data word width.
REQ-003 SHALL take parameter AW, default 22: physical address width.
REQ-004 SHALL take parameter NWORDS, default 4: words per quad transfer, power of two.
REQ-005 SHALL take parameter ACK_TMO, default 255: cycles allowed per ACKN/DATA_VALID wait.
REQ-006 SHALL have ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- CROBAR  in  1  reset; synchronous, active-high.
- RQ_VALID / RQ_READY  in / out  1  MBOX request handshake.
- RQ_ADR  in  AW  address.
- RQ_WR  in  1  1=write, 0=read.
- RQ_MASK  in  NWORDS  words requested.
- WD_DATA  in  DW  write word.
- WD_VALID / WD_READY  in / out  1  write-word handshake.
- RD_DATA  out  DW  read word.
- RD_IDX  out  log2(NWORDS)  read word index.
- RD_VALID  out  1  read word strobe.
- RD_PAR_ERR  out  1  read parity error.
- DONE  out  1  transfer-complete pulse.
- ERR  out  1  error pulse.
- ERR_CODE  out  2  1=timeout, 2=address parity, 3=SBUS ERROR.
- SB_START  out  NPORTS  start, one-hot.
- SB_RQ  out  NWORDS  word request lines.
- SB_RD_RQ / SB_WR_RQ  out  1  direction.
- SB_ADR  out  AW  held address.
- SB_ADR_PAR  out  1  odd address parity.
- SB_ACKN / SB_ERROR / SB_ADR_PAR_ERR / SB_DVALID_IN  in  NPORTS  per-port responses.
- SB_D_IN / SB_D_OUT  in / out  DW  data bus.
- SB_DPAR_IN / SB_DPAR_OUT  in / out  1  odd data parity.
- SB_DVALID_OUT  out  1  write data strobe.
- SB_D_OE  out  1  data-to-memory enable.

Function
REQ-007 SHALL compute port P = RQ_ADR[log2(NWORDS) +: log2(NPORTS)] (P=0 when NPORTS=1), latched with ADR/WR/MASK at acceptance.
REQ-008 SHALL implement FSM IDLE, START, ACK, XFER, DONE, ERR.
REQ-009 IDLE: RQ_READY=1; RQ_VALID accepted -> START; RQ_MASK=0 -> DONE directly with no SBUS activity.
REQ-010 START (1 cycle): SB_START[P]=1, SB_RQ=mask, SB_RD_RQ/SB_WR_RQ per RQ_WR, SB_ADR=latched address, SB_ADR_PAR=~^SB_ADR -> ACK.
REQ-011 ACK: SB_START[P], SB_RQ, direction and SB_ADR SHALL hold until SB_ACKN[P]; SB_ACKN[P] with SB_ADR_PAR_ERR[P] in same cycle -> ERR code 2; SB_ACKN[P] alone -> XFER.
REQ-012 Wait timer SHALL clear on entry to ACK and on every accepted word; reaching ACK_TMO -> ERR code 1.
REQ-013 XFER read: each SB_DVALID_IN[P] cycle SHALL register SB_D_IN, giving next-cycle RD_VALID=1, RD_DATA, RD_IDX=lowest remaining mask bit, RD_PAR_ERR=~(^SB_D_IN ^ SB_DPAR_IN); that mask bit clears; last word -> DONE.
REQ-014 XFER write: SB_D_OE=1; WD_READY=1 only when no word is being driven; accepted word SHALL appear next cycle on SB_D_OUT with SB_DPAR_OUT=~^word and SB_DVALID_OUT=1 for exactly one cycle; last word -> DONE.
REQ-015 SB_ERROR[P] in ACK or XFER -> ERR code 3; takes priority over timeout and parity error in the same cycle.
REQ-016 DONE and ERR SHALL each last one cycle, pulse their output, deassert all SB_* strobes, then -> IDLE; RQ_READY=0 throughout.
REQ-017 Inputs from ports other than P SHALL be ignored.
REQ-018 SB_D_OE SHALL be 0 outside write XFER.

Reset
REQ-019 CROBAR=1 SHALL force IDLE, clear all latches and timer, drive every output 0 (including RQ_READY), and abort any transfer mid-operation with no DONE/ERR; RQ_READY=1 in the first cycle after release.

Verification
REQ-020 Read, NPORTS=2, ADR=0o000004, MASK=1111: ACKN on port 1 after 3 cycles, 4 DVALIDs -> SB_START=10, RD_IDX 0..3, DONE once.
REQ-021 Write, MASK=0101, WD_VALID always 1 -> two one-cycle SB_DVALID_OUT pulses, correct SB_DPAR_OUT, SB_D_OE only in XFER.
REQ-022 Read, no ACKN -> ERR=1, ERR_CODE=1 after ACK_TMO cycles; SB_START low the next cycle.
REQ-023 ACKN with ADR_PAR_ERR -> ERR_CODE=2; SB_ERROR coinciding with bad data parity -> ERR_CODE=3.
REQ-024 CROBAR asserted mid-XFER -> all outputs 0 the next cycle, no DONE/ERR; new request completes normally.
